// File: rtl/lc3_mem_controller.sv
// lc3_mem_controller: word-addressed 16-bit RAM slave for the lc3 core memory port.
// Each access is latched in IDLE and then waits WAIT_CYCLES cycles. memRDY pulses in RESP,
// and a HOLD cycle separates consecutive accesses.
// Addresses at or above 2**DEPTH_W complete with bus_err: reads return zero and writes are dropped.
// Optional feature: define LC3_MEM_PARITY_EN to store an even-parity bit with each word
// and to add the parity_err output port.
module lc3_mem_controller #(
  parameter int DEPTH_W     = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memEN,
  input  logic        memWE,
  input  logic [15:0] memory_addr,
  input  logic [15:0] memory_din,
  output logic [15:0] memory_dout,
  output logic        memRDY,
  output logic        bus_err
`ifdef LC3_MEM_PARITY_EN
  ,
  output logic        parity_err
`endif
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range_check
      $error("lc3_mem_controller: WAIT_CYCLES must be within 0..15");
    end
  endgenerate

`ifdef LC3_MEM_PARITY_EN
  localparam int WORD_W = 17;
`else
  localparam int WORD_W = 16;
`endif
  localparam int NWORDS = 1 << DEPTH_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] din_q;
  logic        we_q;
  logic        in_range_q;
  logic        perr_q;

  logic [WORD_W-1:0] mem [0:NWORDS-1];

  // In IDLE, the request comes straight from the port. Later, it comes from the latched copy.
  logic [15:0]        req_addr;
  logic               req_we;
  logic               req_in_range;
  logic [DEPTH_W-1:0] req_idx;
  logic               accept;
  logic               load_rd;
  logic [WORD_W-1:0]  wr_word;

  assign accept       = (state == ST_IDLE) && memEN;
  assign req_addr     = (state == ST_IDLE) ? memory_addr : addr_q;
  assign req_we       = (state == ST_IDLE) ? memWE : we_q;
  assign req_in_range = ((req_addr >> DEPTH_W) == 16'd0);
  assign req_idx      = req_addr[DEPTH_W-1:0];
  // Read data is registered on the edge that enters RESP, so it is visible during RESP.
  assign load_rd      = (state_next == ST_RESP) && !req_we;

`ifdef LC3_MEM_PARITY_EN
  assign wr_word = {^din_q, din_q};
`else
  assign wr_word = din_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; memEN is looked at only in IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (memEN) state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_next = ST_RESP;
      ST_RESP: state_next = ST_HOLD;
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: completion pulses exist only in RESP
  always_comb begin
    memRDY  = (state == ST_RESP);
    bus_err = (state == ST_RESP) && !in_range_q;
`ifdef LC3_MEM_PARITY_EN
    parity_err = (state == ST_RESP) && !we_q && perr_q;
`endif
  end

  // Request latch, wait counter and registered read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= 4'd0;
      addr_q      <= 16'h0000;
      din_q       <= 16'h0000;
      we_q        <= 1'b0;
      in_range_q  <= 1'b1;
      perr_q      <= 1'b0;
      memory_dout <= 16'h0000;
    end else begin
      if (accept) begin
        cnt        <= WAIT_INIT;
        addr_q     <= memory_addr;
        din_q      <= memory_din;
        we_q       <= memWE;
        in_range_q <= req_in_range;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (load_rd) begin
        memory_dout <= req_in_range ? mem[req_idx][15:0] : 16'h0000;
        perr_q      <= req_in_range && (^mem[req_idx]);
      end
    end
  end

  // RAM write commits at the end of RESP; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (state == ST_RESP && we_q && in_range_q)
      mem[addr_q[DEPTH_W-1:0]] <= wr_word;
  end

endmodule

// File: tb/tb_lc3_mem_controller.sv
// Scoreboard bench for lc3_mem_controller.
// u_dut uses WAIT_CYCLES=2 and receives random plus directed traffic.
// u_dut0 uses WAIT_CYCLES=0 and receives directed latency and HOLD checks.
module tb_lc3_mem_controller;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en = 1'b0, we = 1'b0;
  logic [15:0] addr = 16'h0, din = 16'h0;
  logic [15:0] dout;
  logic        rdy, berr;
  logic        en0 = 1'b0, we0 = 1'b0;
  logic [15:0] addr0 = 16'h0, din0 = 16'h0;
  logic [15:0] dout0;
  logic        rdy0, berr0;
`ifdef LC3_MEM_PARITY_EN
  logic        perr, perr0;
`endif

  lc3_mem_controller #(.DEPTH_W(12), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .memEN(en), .memWE(we), .memory_addr(addr), .memory_din(din),
    .memory_dout(dout), .memRDY(rdy), .bus_err(berr)
`ifdef LC3_MEM_PARITY_EN
    , .parity_err(perr)
`endif
  );

  lc3_mem_controller #(.DEPTH_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .memEN(en0), .memWE(we0), .memory_addr(addr0), .memory_din(din0),
    .memory_dout(dout0), .memRDY(rdy0), .bus_err(berr0)
`ifdef LC3_MEM_PARITY_EN
    , .parity_err(perr0)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] dout;
    logic        berr;
    logic        perr;
    int unsigned cyc;
    logic [15:0] addr;
    logic        we;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: the memory content as the core should see it
  logic [15:0] ref_mem [int];
  bit          corrupt [int];
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] pool [16];
  logic [15:0] fixed_a [7] = '{16'h0000, 16'h0010, 16'h0040, 16'h0100, 16'h0123, 16'h0200, 16'h0FFF};

  function automatic bit in_rng(input logic [15:0] a);
    return a < 16'h1000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per memRDY pulse
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_rdy: got memRDY=1 expected no pending access");
      end else begin
        mon_e = sb.pop_front();
        $display("txn %s addr=%h dout=%h bus_err=%b cyc=%0d", mon_e.we ? "WR" : "RD",
                 mon_e.addr, dout, berr, cyc);
        check("latency", cyc, mon_e.cyc);
        check("dout", {16'h0, dout}, {16'h0, mon_e.dout});
        check("bus_err", {31'h0, berr}, {31'h0, mon_e.berr});
`ifdef LC3_MEM_PARITY_EN
        check("parity_err", {31'h0, perr}, {31'h0, mon_e.perr});
`endif
      end
    end else if (berr !== 1'b0) begin
      vectors++; miscompares++;
      $display("FAIL stray_bus_err: got bus_err=%b expected 0 without memRDY", berr);
    end
  end

  // Driver: called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input bit scr, input logic [15:0] scr_a);
    exp_t e;
    bit done;
    en = 1'b1; we = w; addr = a; din = d;
    e.cyc = cyc + 1 + W; e.we = w; e.addr = a;
    if (w) begin
      if (in_rng(a)) begin ref_mem[int'(a)] = d; corrupt[int'(a)] = 1'b0; end
    end else begin
      last_rd = in_rng(a) ? ref_mem[int'(a)] : 16'h0000;
    end
    e.dout = last_rd;
    e.berr = !in_rng(a);
    e.perr = !w && in_rng(a) && corrupt.exists(int'(a)) && corrupt[int'(a)];
    sb.push_back(e);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (rdy) done = 1'b1;
      else if (k == 0 && scr) begin en = 1'b0; addr = scr_a; din = 16'($urandom); end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL timeout: got no memRDY for addr %h expected one within 40 cycles", a);
    end
    en = 1'b0; we = 1'($urandom); addr = 16'($urandom); din = 16'($urandom);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n_rdy;
    int unsigned c0, rdy_cyc;
    logic [15:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_memRDY", {31'h0, rdy}, 32'h0);
    check("rst_bus_err", {31'h0, berr}, 32'h0);
    check("rst_dout", {16'h0, dout}, 32'h0);
    check("rst_dout0", {16'h0, dout0}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Initialise every address the random phase will read
    for (int i = 0; i < 16; i++)
      pool[i] = (i < 7) ? fixed_a[i] : 16'($urandom_range(1, 4095));
    for (int i = 0; i < 16; i++) access(1'b1, pool[i], 16'($urandom), 1'b0, 16'h0);

    // Directed: latency of write, then readback of new data
    access(1'b1, 16'h0123, 16'hBEEF, 1'b0, 16'h0);
    access(1'b0, 16'h0123, 16'h0, 1'b0, 16'h0);
    // Out of range write/read, base address untouched
    access(1'b1, 16'h1000, 16'h5555, 1'b0, 16'h0);
    access(1'b0, 16'h1000, 16'h0, 1'b0, 16'h0);
    access(1'b0, 16'h0000, 16'h0, 1'b0, 16'h0);
    // Port changes during WAIT must not alter the latched read
    access(1'b0, 16'h0100, 16'h0, 1'b1, 16'h0200);

    // Reset in the middle of a write: no completion, no write
    en = 1'b1; we = 1'b1; addr = 16'h0010; din = 16'hDEAD;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    #1;
    check("abort_memRDY", {31'h0, rdy}, 32'h0);
    check("abort_dout", {16'h0, dout}, 32'h0);
    repeat (2) @(negedge clk);
    check("abort_memRDY_late", {31'h0, rdy}, 32'h0);
    rst = 1'b1;
    last_rd = 16'h0000;
    @(negedge clk);
    access(1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);

`ifdef LC3_MEM_PARITY_EN
    // Backdoor corruption of a stored word
    u_dut.mem[12'h040][3] = ~u_dut.mem[12'h040][3];
    ref_mem[16'h0040] = ref_mem[16'h0040] ^ 16'h0008;
    corrupt[16'h0040] = 1'b1;
    access(1'b0, 16'h0040, 16'h0, 1'b0, 16'h0);
    access(1'b0, 16'h0000, 16'h0, 1'b0, 16'h0);
`endif

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'hFFFF, 16'h1000));
      else a = pool[$urandom_range(0, 15)];
      access(1'($urandom), a, 16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Zero-wait instance: write with memEN held through HOLD gives only one memRDY
    en0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; din0 = 16'h1234;
    c0 = cyc; n_rdy = 0; rdy_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rdy0) begin n_rdy++; rdy_cyc = cyc; end
      if (k == 2) en0 = 1'b0;
    end
    check("w0_rdy_count", n_rdy, 1);
    check("w0_latency", rdy_cyc, c0 + 1);
    // Zero-wait read returns the new data one cycle after accept
    en0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
    c0 = cyc; n_rdy = 0; rdy_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rdy0) begin
        n_rdy++; rdy_cyc = cyc;
        check("r0_dout", {16'h0, dout0}, 32'h1234);
        check("r0_bus_err", {31'h0, berr0}, 32'h0);
      end
      en0 = 1'b0;
    end
    check("r0_rdy_count", n_rdy, 1);
    check("r0_latency", rdy_cyc, c0 + 1);

    // Drain
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: got %0d pending accesses expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
